yc_chroma_sequencer: RTL



---
 rtl/yc_chroma_sequencer_pkg.sv | 55 +++++
 rtl/yc_chroma_sequencer_if.sv | 26 ++
 rtl/yc_chroma_sequencer_sync_edge_det.sv | 20 ++
 rtl/yc_chroma_sequencer.sv | 88 ++++++++
 4 files changed

// File: rtl/yc_chroma_sequencer_pkg.sv
// Shared Y/C chroma constants, sequencer state type, next-state rule and the subcarrier LUTs.
package yc_pkg;

    localparam int unsigned YC_LUT_LEN     = 14;
    localparam int unsigned YC_BURST_START = 20;
    localparam int unsigned YC_BURST_LEN   = 136;
    localparam int unsigned YC_POS_SAT     = 300;
    localparam int unsigned YC_CNT_W       = 9;
    localparam int unsigned YC_LINE_W      = 10;
    localparam int unsigned YC_PHASE_W     = 5;
    localparam int unsigned YC_LUT_W       = 8;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        PORCH,
        BURST,
        ACTIVE
    } yc_seq_state_t;

    typedef logic signed [YC_LUT_W-1:0] yc_lut_t [YC_LUT_LEN];

    // 127 * sin/cos(2*pi*k/14); the modulator indexes these with phase_idx.
    localparam yc_lut_t YC_SIN_LUT = '{
        8'sd0,    8'sd55,   8'sd99,   8'sd124,  8'sd124,  8'sd99,   8'sd55,
        8'sd0,   -8'sd55,  -8'sd99,  -8'sd124, -8'sd124, -8'sd99,  -8'sd55
    };
    localparam yc_lut_t YC_COS_LUT = '{
        8'sd127,  8'sd114,  8'sd79,   8'sd28,  -8'sd28,  -8'sd79,  -8'sd114,
       -8'sd127, -8'sd114, -8'sd79,  -8'sd28,   8'sd28,   8'sd79,   8'sd114
    };

    // Priority-ordered transition rule; pos is the pre-edge in-line position.
    function automatic yc_seq_state_t yc_next_state(
        input logic                enable,
        input logic                hsync,
        input logic                vsync,
        input logic [YC_CNT_W-1:0] pos
    );
        yc_seq_state_t nxt;
        nxt = ACTIVE;
        if (!enable)
            nxt = IDLE;
        else if (hsync)
            nxt = SYNC;
        else if (vsync)
            nxt = PORCH;
        else if (pos < YC_CNT_W'(YC_BURST_START))
            nxt = PORCH;
        else if (pos < YC_CNT_W'(YC_BURST_START + YC_BURST_LEN))
            nxt = BURST;
        return nxt;
    endfunction

endpackage

// File: rtl/yc_chroma_sequencer_if.sv
// Control inputs and timing outputs between the video timing source, sequencer and modulator.
interface yc_chroma_sequencer_if;
    import yc_pkg::*;

    logic                  enable;
    logic                  hsync;
    logic                  vsync;
    logic                  phase_reset_en;
    logic [YC_PHASE_W-1:0] phase_idx;
    logic                  burst_gate;
    logic                  chroma_gate;
    logic                  line_start;
    logic [YC_LINE_W-1:0]  line_cnt;
    logic                  field;

    modport master (
        output enable, hsync, vsync, phase_reset_en,
        input  phase_idx, burst_gate, chroma_gate, line_start, line_cnt, field
    );

    modport slave (
        input  enable, hsync, vsync, phase_reset_en,
        output phase_idx, burst_gate, chroma_gate, line_start, line_cnt, field
    );

endinterface

// File: rtl/yc_chroma_sequencer_sync_edge_det.sv
// Rising-edge detector: compares a sync input with its one-cycle delayed copy.
module sync_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise_c
);

    logic din_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            din_d <= 1'b0;
        else
            din_d <= din;
    end

    assign rise_c = din & ~din_d;

endmodule

// File: rtl/yc_chroma_sequencer.sv
// Subcarrier phase, burst/active-chroma gating and line/field counting for the Y/C modulator.
module yc_chroma_sequencer
    import yc_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    yc_chroma_sequencer_if.slave  bus
);

    logic                  h_rise_c;
    logic                  v_rise_c;
    yc_seq_state_t         state;
    yc_seq_state_t         state_nxt_c;
    logic [YC_CNT_W-1:0]   pos_cnt;
    logic [YC_PHASE_W-1:0] phase_idx;
    logic                  line_start;
    logic [YC_LINE_W-1:0]  line_cnt;
    logic                  field;

    sync_edge_det u_hsync_det (
        .clk    (clk),
        .reset  (reset),
        .din    (bus.hsync),
        .rise_c (h_rise_c)
    );

    sync_edge_det u_vsync_det (
        .clk    (clk),
        .reset  (reset),
        .din    (bus.vsync),
        .rise_c (v_rise_c)
    );

    assign state_nxt_c = yc_next_state(bus.enable, bus.hsync, bus.vsync, pos_cnt);

    // Line FSM plus the saturating in-line position counter it keys off.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            pos_cnt <= '0;
        end else begin
            state <= state_nxt_c;
            if (bus.hsync)
                pos_cnt <= '0;
            else if (pos_cnt != YC_CNT_W'(YC_POS_SAT))
                pos_cnt <= pos_cnt + 1'b1;
        end
    end

    // Subcarrier LUT index, optionally re-phased at each line start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            phase_idx <= '0;
        else if (!bus.enable)
            phase_idx <= '0;
        else if (bus.phase_reset_en && h_rise_c)
            phase_idx <= '0;
        else if (phase_idx == YC_PHASE_W'(YC_LUT_LEN - 1))
            phase_idx <= '0;
        else
            phase_idx <= phase_idx + 1'b1;
    end

    // Line/field bookkeeping; a vsync rise wins over a coincident hsync rise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            line_start <= 1'b0;
            line_cnt   <= '0;
            field      <= 1'b0;
        end else begin
            line_start <= h_rise_c;
            if (v_rise_c) begin
                line_cnt <= '0;
                field    <= ~field;
            end else if (h_rise_c && (line_cnt != '1)) begin
                line_cnt <= line_cnt + 1'b1;
            end
        end
    end

    assign bus.phase_idx   = phase_idx;
    assign bus.burst_gate  = (state == BURST);
    assign bus.chroma_gate = (state == ACTIVE);
    assign bus.line_start  = line_start;
    assign bus.line_cnt    = line_cnt;
    assign bus.field       = field;

endmodule
